// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, iteration count
// and the field layout of the 64-bit {HI, LO} result.
package div_pkg;

   localparam int unsigned DIV_CYCLES = 32;

   // Result field indices: remainder goes to HI, quotient goes to LO.
   localparam int unsigned DIV_HI_MSB = 63;
   localparam int unsigned DIV_HI_LSB = 32;
   localparam int unsigned DIV_LO_MSB = 31;
   localparam int unsigned DIV_LO_LSB = 0;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step.
// Ports:
//   rem_i   - current partial remainder (always < divisor)
//   msb_i   - dividend bit shifted into the remainder this step
//   dvs_i   - divisor magnitude
//   rem_c_o - next partial remainder (combinational)
//   q_c_o   - quotient bit produced by this step (combinational)
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             msb_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_c_o,
   output logic             q_c_o
);

   logic [WIDTH:0] shifted_c;
   logic [WIDTH:0] trial_c;

   // The shifted remainder needs WIDTH+1 bits because it can reach 2*dvs-1.
   always_comb begin
      shifted_c = {rem_i, msb_i};
      trial_c   = shifted_c - {1'b0, dvs_i};
      if (!trial_c[WIDTH]) begin
         rem_c_o = trial_c[WIDTH-1:0];
         q_c_o   = 1'b1;
      end else begin
         rem_c_o = shifted_c[WIDTH-1:0];
         q_c_o   = 1'b0;
      end
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU behind the execute stage.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   sign_i    - 1 = signed divide, sampled with start_i
//   op1_i     - dividend, op2_i - divisor (sampled only when accepted)
//   start_i   - request, held high until ready_o is seen
//   annul_i   - abort an in-flight divide (flush)
//   result_o  - {remainder, quotient}, valid while ready_o is high
//   ready_o   - completion flag, held while start_i stays high
module div_iter
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sign_i,
   input  logic [WIDTH-1:0]   op1_i,
   input  logic [WIDTH-1:0]   op2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sign_q, sign_d;
   logic               neg1_q, neg1_d;
   logic               neg2_q, neg2_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;

   logic [WIDTH-1:0]   op1_abs_c, op2_abs_c;
   logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;
   logic [WIDTH-1:0]   rem_step_c;
   logic               qbit_c;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i   (rem_q),
      .msb_i   (dvd_q[WIDTH-1]),
      .dvs_i   (dvs_q),
      .rem_c_o (rem_step_c),
      .q_c_o   (qbit_c)
   );

   // Operand magnitudes; |most-negative| wraps to itself, which the
   // WIDTH+1-bit trial subtraction treats correctly as unsigned.
   always_comb begin
      op1_abs_c = (sign_i && op1_i[WIDTH-1]) ? (~op1_i + WIDTH'(1)) : op1_i;
      op2_abs_c = (sign_i && op2_i[WIDTH-1]) ? (~op2_i + WIDTH'(1)) : op2_i;
   end

   // Sign restoration: quotient follows sign(op1)^sign(op2), remainder follows op1.
   always_comb begin
      quo_fix_c = (sign_q && (neg1_q ^ neg2_q)) ? (~dvd_q + WIDTH'(1)) : dvd_q;
      rem_fix_c = (sign_q && neg1_q)            ? (~rem_q + WIDTH'(1)) : rem_q;
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      result_d = result_q;
      ready_d  = ready_q;

      if (annul_i && (state_q != DIV_FREE)) begin
         state_d  = DIV_FREE;
         ready_d  = 1'b0;
         result_d = '0;
      end else begin
         unique case (state_q)
            DIV_FREE: begin
               if (start_i && !annul_i) begin
                  sign_d = sign_i;
                  neg1_d = op1_i[WIDTH-1];
                  neg2_d = op2_i[WIDTH-1];
                  dvs_d  = op2_abs_c;
                  if (op2_i == '0) begin
                     state_d = DIV_BYZERO;
                  end else begin
                     state_d = DIV_ON;
                     cnt_d   = '0;
                     rem_d   = '0;
                     dvd_d   = op1_abs_c;
                  end
               end
            end
            DIV_ON: begin
               if (cnt_q != CNT_W'(WIDTH)) begin
                  // Dividend register doubles as the quotient shift register.
                  rem_d = rem_step_c;
                  dvd_d = {dvd_q[WIDTH-2:0], qbit_c};
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  result_d = {rem_fix_c, quo_fix_c};
                  ready_d  = 1'b1;
                  state_d  = DIV_END;
               end
            end
            DIV_BYZERO: begin
               result_d = '0;
               ready_d  = 1'b1;
               state_d  = DIV_END;
            end
            DIV_END: begin
               if (!start_i) begin
                  state_d  = DIV_FREE;
                  ready_d  = 1'b0;
                  result_d = '0;
               end
            end
            default: state_d = DIV_FREE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         dvs_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed corner cases plus random divides compared
// against an arithmetic reference (SV integer division on 64-bit values).
module tb_div_iter;
   import div_pkg::*;

   logic        clk;
   logic        rst;
   logic        sign_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks;
   int errors;

   div_iter #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .sign_i   (sign_i),
      .op1_i    (op1_i),
      .op2_i    (op2_i),
      .start_i  (start_i),
      .annul_i  (annul_i),
      .result_o (result_o),
      .ready_o  (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Reference: HI = remainder, LO = quotient, truncating division; x/0 -> 0.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      res = 64'd0;
      res[DIV_HI_MSB:DIV_HI_LSB] = r[31:0];
      res[DIV_LO_MSB:DIV_LO_LSB] = q[31:0];
      return res;
   endfunction

   // Issue one divide, check latency/result/hold, then release start.
   task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
      logic [63:0] exp;
      int exp_lat;
      int n;
      exp     = model(s, a, b);
      exp_lat = (b == 32'd0) ? 2 : 34;
      @(negedge clk);
      sign_i  = s;
      op1_i   = a;
      op2_i   = b;
      start_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (n == 4) begin
            op1_i  = $urandom;
            op2_i  = $urandom;
            sign_i = 1'($urandom_range(0, 1));
         end
      end while (!ready_o && n < 60);
      chk({tag, " latency"}, 64'(n), 64'(exp_lat));
      chk({tag, " result"}, result_o, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
         chk({tag, " hold result"}, result_o, exp);
      end
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " release ready"}, 64'(ready_o), 64'd0);
      chk({tag, " release result"}, result_o, 64'd0);
   endtask

   // Start a divide and abort it after 'at' edges using annul or reset.
   task automatic abort_div(input int at, input logic use_rst, input string tag);
      int seen_ready;
      @(negedge clk);
      sign_i  = 1'b0;
      op1_i   = $urandom;
      op2_i   = 32'd3;
      start_i = 1'b1;
      for (int i = 1; i < at; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      if (use_rst) rst = 1'b1;
      else         annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      annul_i = 1'b0;
      start_i = 1'b0;
      chk({tag, " ready"}, 64'(ready_o), 64'd0);
      chk({tag, " result"}, result_o, 64'd0);
      seen_ready = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o) seen_ready++;
      end
      chk({tag, " ready stays low"}, 64'(seen_ready), 64'd0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      sign_i  = 1'b0;
      op1_i   = '0;
      op2_i   = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      rst = 1'b0;

      run_div(1'b0, 32'd7, 32'd2, 2, "u7/2");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, "s-7/2");
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1, "s7/-2");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "ovf");
      run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1, "uffff/16");
      run_div(1'b0, 32'd5, 32'd0, 10, "dbz");
      run_div(1'b1, 32'h8000_0000, 32'd1, 0, "min/1");

      abort_div(15, 1'b0, "annul");
      run_div(1'b0, 32'd100, 32'd7, 0, "100/7");
      abort_div(20, 1'b1, "midrst");
      run_div(1'b0, 32'd100, 32'd7, 0, "post-rst");

      for (int k = 0; k < 24; k++) begin
         logic        s;
         logic [31:0] a, b;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = {$urandom} >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_div(s, a, b, 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider that sits directly downstream of the execute stage.
- Consumes the execute stage's divide request (operands, start, sign) and returns a 64-bit {remainder, quotient} result plus a completion flag.
- Execute holds start high and stalls the pipeline until completion, then writes HI/LO.
- Handles signed and unsigned DIV/DIVU, divide-by-zero, and annulment on exception flush.

Parameters:
- WIDTH, 32, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- sign_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- op1_i  input  WIDTH  dividend
- op2_i  input  WIDTH  divisor
- start_i  input  1  request; held high by execute until ready_o is seen
- annul_i  input  1  abort in-flight divide (exception/flush)
- result_o  output  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready_o  output  1  result valid; stays high while start_i stays high

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on rst=1 at an edge, state=FREE, cnt=0, ready_o=0, result_o=0, all internal registers = 0.
- States are FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0: latch sign, the operand signs, and magnitudes. Magnitude is the two's-complement abs when sign_i=1 and the operand's MSB is 1, otherwise the raw value.
  - If op2_i==0, go to BYZERO; else go to ON with cnt=0, partial remainder=0, dividend shift register=|op1|.
  - Otherwise stay in FREE.
- ON, with cnt<WIDTH, one iteration per edge:
  - Shift {rem, dvd} left by 1.
  - Trial = rem - |op2| (WIDTH+1 bits).
  - If trial is non-negative, rem=trial[WIDTH-1:0] and quotient bit=1; else quotient bit=0.
  - cnt++.
- ON, with cnt==WIDTH:
  - Apply sign correction. Quotient is negated if sign and (op1 MSB xor op2 MSB). Remainder is negated if sign and op1 MSB.
  - Load result_o, set ready_o=1, go to END.
- BYZERO: next edge loads result_o=0, sets ready_o=1, goes to END.
- END:
  - Hold result_o and ready_o while start_i=1.
  - On start_i=0: go to FREE, ready_o=0, result_o=0.
- Latency, numbering the edge at which start is first sampled as E1:
  - Normal divide: iterations at E2..E33, finalize at E34; ready_o high after E34.
  - Divide-by-zero: ready_o high after E2.
- annul_i=1 in any state other than FREE → next edge goes to FREE, ready_o=0, result_o=0. annul_i has priority over start_i and over completion.
- Operand changes on op*_i after E1 are ignored; the latched values are used.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0 (natural wrap, no trap).
- |0x80000000| in signed mode is treated as the unsigned 0x80000000, which is correct through the WIDTH+1-bit trial.
- start_i dropping while in ON or BYZERO has no effect; only annul_i aborts.
- Back-to-back divides: a new start is accepted only from FREE, so at least one start_i=0 cycle is needed between requests.
- Reset mid-operation behaves identically to annul_i, and rst dominates annul_i.

Decomposition:
- Shared package div_pkg holds:
  - the state encoding (DIV_FREE=2'b00, DIV_BYZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11);
  - DIV_CYCLES=32;
  - the result field indices (HI=[63:32], LO=[31:0]).
- One natural combinational sub-module, div_step: takes rem, the dividend MSB, and the divisor, and returns next rem and the quotient bit. The FSM, counter, and sign logic stay in div_iter.

Test Plan:
- Unsigned 7/2: start=1 held, sign=0 → ready_o rises after E34; result_o=0x00000001_00000003; drop start → ready_o=0 and result_o=0 the next cycle.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 → 0x00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. Unsigned 0xFFFFFFFF / 0x00000010 → 0x0000000F_0FFFFFFF.
- Divide-by-zero 5/0 → ready_o high after E2, result_o=0; ready_o holds for 10 cycles while start stays high.
- annul_i pulsed at E15 of a divide → FREE at E16 and ready_o never asserts. A new 100/7 started two cycles later → 0x00000002_0000000E after its E34.
- rst asserted at E20 mid-divide → ready_o=0, result_o=0, next start accepted normally. op1_i changed at E5 → result unaffected.
